// File: rtl/magic_slot_streamer.sv
// Multi-slot AXI-Stream capture/replay buffer: stores a stream into one of NUM_SLOTS slots and replays it later.
// Optional macro MAGIC_STREAMER_KEEP_STORE_EN stores TKEEP per word and replays it; otherwise M_AXI_TKEEP is all-ones.
module magic_slot_streamer #(
  parameter int DATA_WIDTH        = 32,
  parameter int STORAGE_IDX_WIDTH = 10,
  parameter int NUM_SLOTS         = 4,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int LEN_W  = STORAGE_IDX_WIDTH + 1,
  localparam int KEEP_W = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] S_AXI_TDATA,
  input  logic [KEEP_W-1:0]     S_AXI_TKEEP,
  input  logic                  S_AXI_TVALID,
  output logic                  S_AXI_TREADY,
  input  logic                  S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0] M_AXI_TDATA,
  output logic [KEEP_W-1:0]     M_AXI_TKEEP,
  output logic                  M_AXI_TVALID,
  input  logic                  M_AXI_TREADY,
  output logic                  M_AXI_TLAST,
  input  logic                  storeReset,
  input  logic                  loadReset,
  input  logic                  storeInit,
  input  logic                  loadInit,
  input  logic [SLOT_W-1:0]     slotSel,
  output logic                  finStore,
  output logic                  finLoad,
  output logic                  overflow,
  output logic                  emptyErr,
  output logic                  busy,
  output logic [3:0]            dbg_state,
  output logic [SLOT_W-1:0]     dbg_slot,
  output logic [LEN_W-1:0]      dbg_amt_store_bytes,
  output logic [LEN_W-1:0]      dbg_amt_load_bytes
);
  localparam int DEPTH  = 1 << STORAGE_IDX_WIDTH;
  localparam int ADDR_W = SLOT_W + STORAGE_IDX_WIDTH;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE      = 2'd1,
    LOAD_PRIME = 2'd2,
    LOAD       = 2'd3
  } state_e;

  state_e                       state_q;
  logic [SLOT_W-1:0]            slot_q;
  logic [STORAGE_IDX_WIDTH-1:0] wr_ptr_q;
  logic [LEN_W-1:0]             store_len_q [NUM_SLOTS];
  logic [STORAGE_IDX_WIDTH-1:0] load_ptr_q  [NUM_SLOTS];
  logic                         fin_store_q, fin_load_q, overflow_q, empty_err_q;
  logic [DATA_WIDTH-1:0]        m_tdata_q;
  logic                         m_tlast_q;

  logic [DATA_WIDTH-1:0]        mem [1 << ADDR_W];

  logic [LEN_W-1:0]             cur_len;
  logic [STORAGE_IDX_WIDTH-1:0] cur_ptr, load_ptr_d, rd_ptr;
  logic [ADDR_W-1:0]            wr_addr, rd_addr;
  logic                         store_beat, load_beat, rd_en, rd_last;

  assign cur_len    = store_len_q[slot_q];
  assign cur_ptr    = load_ptr_q[slot_q];
  assign load_ptr_d = cur_ptr + STORAGE_IDX_WIDTH'(1);
  assign store_beat = reset && (state_q == STORE) && S_AXI_TVALID;
  assign load_beat  = (state_q == LOAD) && M_AXI_TREADY;

  // The output register is refilled in LOAD_PRIME and on every non-final handshake,
  // so the next word is already waiting and the stream runs without bubbles.
  assign rd_en   = (state_q == LOAD_PRIME) || (load_beat && !m_tlast_q);
  assign rd_ptr  = (state_q == LOAD_PRIME) ? cur_ptr : load_ptr_d;
  assign rd_addr = {slot_q, rd_ptr};
  assign rd_last = ({1'b0, rd_ptr} == (cur_len - LEN_W'(1)));
  assign wr_addr = {slot_q, wr_ptr_q};

  // NOTE: storage has no reset; contents survive reset and only lengths/pointers are cleared.
  always_ff @(posedge clk) begin
    if (store_beat) mem[wr_addr] <= S_AXI_TDATA;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      wr_ptr_q    <= '0;
      fin_store_q <= 1'b0;
      fin_load_q  <= 1'b0;
      overflow_q  <= 1'b0;
      empty_err_q <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        store_len_q[i] <= '0;
        load_ptr_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (storeReset) begin
            slot_q               <= slotSel;
            store_len_q[slotSel] <= '0;
            fin_store_q          <= 1'b0;
            overflow_q           <= 1'b0;
          end else if (loadReset) begin
            slot_q              <= slotSel;
            load_ptr_q[slotSel] <= '0;
            fin_load_q          <= 1'b0;
            empty_err_q         <= 1'b0;
          end else if (storeInit) begin
            slot_q   <= slotSel;
            wr_ptr_q <= '0;
            state_q  <= STORE;
          end else if (loadInit) begin
            slot_q <= slotSel;
            if (store_len_q[slotSel] == '0) empty_err_q <= 1'b1;
            else                            state_q     <= LOAD_PRIME;
          end
        end
        STORE: begin
          if (S_AXI_TVALID) begin
            if (cur_len != LEN_W'(DEPTH)) store_len_q[slot_q] <= cur_len + LEN_W'(1);
            wr_ptr_q <= wr_ptr_q + STORAGE_IDX_WIDTH'(1);
            if (S_AXI_TLAST) begin
              fin_store_q <= 1'b1;
              state_q     <= IDLE;
            end else if (&wr_ptr_q) begin
              overflow_q  <= 1'b1;
              fin_store_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        LOAD_PRIME: state_q <= LOAD;
        LOAD: begin
          if (M_AXI_TREADY) begin
            if (m_tlast_q) begin
              fin_load_q         <= 1'b1;
              load_ptr_q[slot_q] <= '0;
              m_tlast_q          <= 1'b0;
              state_q            <= IDLE;
            end else begin
              load_ptr_q[slot_q] <= load_ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (rd_en) begin
        m_tdata_q <= mem[rd_addr];
        m_tlast_q <= rd_last;
      end
    end
  end

`ifdef MAGIC_STREAMER_KEEP_STORE_EN
  logic [KEEP_W-1:0] keep_mem [1 << ADDR_W];
  logic [KEEP_W-1:0] m_tkeep_q;

  always_ff @(posedge clk) begin
    if (store_beat) keep_mem[wr_addr] <= S_AXI_TKEEP;
  end

  always_ff @(posedge clk) begin
    if (!reset)     m_tkeep_q <= '0;
    else if (rd_en) m_tkeep_q <= keep_mem[rd_addr];
  end

  assign M_AXI_TKEEP = m_tkeep_q;
`else
  logic unused_keep;
  assign unused_keep = ^S_AXI_TKEEP;
  assign M_AXI_TKEEP = '1;
`endif

  assign S_AXI_TREADY        = (state_q == STORE);
  assign M_AXI_TVALID        = (state_q == LOAD);
  assign M_AXI_TDATA         = m_tdata_q;
  assign M_AXI_TLAST         = m_tlast_q && (state_q == LOAD);
  assign finStore            = fin_store_q;
  assign finLoad             = fin_load_q;
  assign overflow            = overflow_q;
  assign emptyErr            = empty_err_q;
  assign busy                = (state_q != IDLE);
  assign dbg_state           = {2'b00, state_q};
  assign dbg_slot            = slot_q;
  assign dbg_amt_store_bytes = cur_len;
  assign dbg_amt_load_bytes  = {1'b0, cur_ptr};

endmodule

// File: tb/tb_magic_slot_streamer.sv
// Scoreboard bench for magic_slot_streamer: expected beats are queued when a load starts and
// compared by a monitor as the master port hands them off.
module tb_magic_slot_streamer;
  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int SW    = 2;
  localparam int LW    = 11;
  localparam int DEPTH = 1024;

  localparam int P_SR = 0;
  localparam int P_LR = 1;
  localparam int P_SI = 2;
  localparam int P_LI = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] S_AXI_TDATA = '0;
  logic [KW-1:0] S_AXI_TKEEP = '0;
  logic          S_AXI_TVALID = 1'b0;
  logic          S_AXI_TREADY;
  logic          S_AXI_TLAST = 1'b0;
  logic [DW-1:0] M_AXI_TDATA;
  logic [KW-1:0] M_AXI_TKEEP;
  logic          M_AXI_TVALID;
  logic          M_AXI_TREADY = 1'b0;
  logic          M_AXI_TLAST;
  logic          storeReset = 1'b0, loadReset = 1'b0, storeInit = 1'b0, loadInit = 1'b0;
  logic [SW-1:0] slotSel = '0;
  logic          finStore, finLoad, overflow, emptyErr, busy;
  logic [3:0]    dbg_state;
  logic [SW-1:0] dbg_slot;
  logic [LW-1:0] dbg_amt_store_bytes, dbg_amt_load_bytes;

  magic_slot_streamer dut (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TKEEP(S_AXI_TKEEP), .S_AXI_TVALID(S_AXI_TVALID),
    .S_AXI_TREADY(S_AXI_TREADY), .S_AXI_TLAST(S_AXI_TLAST),
    .M_AXI_TDATA(M_AXI_TDATA), .M_AXI_TKEEP(M_AXI_TKEEP), .M_AXI_TVALID(M_AXI_TVALID),
    .M_AXI_TREADY(M_AXI_TREADY), .M_AXI_TLAST(M_AXI_TLAST),
    .storeReset(storeReset), .loadReset(loadReset), .storeInit(storeInit), .loadInit(loadInit),
    .slotSel(slotSel), .finStore(finStore), .finLoad(finLoad), .overflow(overflow),
    .emptyErr(emptyErr), .busy(busy), .dbg_state(dbg_state), .dbg_slot(dbg_slot),
    .dbg_amt_store_bytes(dbg_amt_store_bytes), .dbg_amt_load_bytes(dbg_amt_load_bytes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_exp;
  int    errors = 0;
  int    checks = 0;
  int    beats_seen = 0;
  logic          hold = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  function automatic logic [KW-1:0] exp_keep(input logic [KW-1:0] k);
`ifdef MAGIC_STREAMER_KEEP_STORE_EN
    return k;
`else
    return 4'hF;
`endif
  endfunction

  // Master-port monitor, sampled on the falling edge: a handshake seen here completes on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checks++;
        if (M_AXI_TVALID !== 1'b1 || M_AXI_TDATA !== held_data || M_AXI_TLAST !== held_last) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%0h last=%0b expected valid=1 data=%0h last=%0b",
                   M_AXI_TVALID, M_AXI_TDATA, M_AXI_TLAST, held_data, held_last);
        end
      end
      if (M_AXI_TVALID === 1'b1 && M_AXI_TREADY === 1'b1) begin
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%0h expected no beat", M_AXI_TDATA);
        end else begin
          mon_exp = exp_q.pop_front();
          if (M_AXI_TDATA !== mon_exp.data || M_AXI_TKEEP !== mon_exp.keep || M_AXI_TLAST !== mon_exp.last) begin
            errors++;
            $display("FAIL beat: got data=%0h keep=%0h last=%0b expected data=%0h keep=%0h last=%0b",
                     M_AXI_TDATA, M_AXI_TKEEP, M_AXI_TLAST, mon_exp.data, mon_exp.keep, mon_exp.last);
          end
        end
      end
      hold      = (M_AXI_TVALID === 1'b1) && (M_AXI_TREADY === 1'b0);
      held_data = M_AXI_TDATA;
      held_last = M_AXI_TLAST;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int kind, input int slot);
    slotSel = slot[SW-1:0];
    case (kind)
      P_SR:    storeReset = 1'b1;
      P_LR:    loadReset  = 1'b1;
      P_SI:    storeInit  = 1'b1;
      default: loadInit   = 1'b1;
    endcase
    step();
    storeReset = 1'b0;
    loadReset  = 1'b0;
    storeInit  = 1'b0;
    loadInit   = 1'b0;
  endtask

  task automatic store_words(input int slot, input int n, input logic [DW-1:0] base, input logic [KW-1:0] last_keep);
    pulse(P_SR, slot);
    pulse(P_SI, slot);
    for (int i = 0; i < n; i++) begin
      S_AXI_TVALID = 1'b1;
      S_AXI_TDATA  = base + DW'(i);
      S_AXI_TKEEP  = (i == n - 1) ? last_keep : 4'hF;
      S_AXI_TLAST  = (i == n - 1);
      checks++;
      if (S_AXI_TREADY !== 1'b1) begin
        errors++;
        $display("FAIL store_tready: got %0b expected 1 (beat %0d)", S_AXI_TREADY, i);
      end
      step();
    end
    S_AXI_TVALID = 1'b0;
    S_AXI_TLAST  = 1'b0;
    checks++;
    if (finStore !== 1'b1 || dbg_state !== 4'd0 || dbg_amt_store_bytes !== LW'(n)) begin
      errors++;
      $display("FAIL store_done: got fin=%0b state=%0d len=%0d expected fin=1 state=0 len=%0d",
               finStore, dbg_state, dbg_amt_store_bytes, n);
    end
  endtask

  // pattern 0: TREADY always high; pattern 1: TREADY 1,0,0,1,0,0,... from the first valid cycle.
  task automatic load_words(input int slot, input int n, input logic [DW-1:0] base,
                            input logic [KW-1:0] last_keep, input int pattern);
    int cyc;
    int seen0;
    beat_t b;
    pulse(P_LR, slot);
    checks++;
    if (finLoad !== 1'b0 || dbg_amt_load_bytes !== '0) begin
      errors++;
      $display("FAIL load_reset: got fin=%0b ptr=%0d expected fin=0 ptr=0", finLoad, dbg_amt_load_bytes);
    end
    for (int i = 0; i < n; i++) begin
      b.data = base + DW'(i);
      b.keep = exp_keep((i == n - 1) ? last_keep : 4'hF);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    seen0 = beats_seen;
    pulse(P_LI, slot);
    cyc = 0;
    while (busy === 1'b1 && cyc < 4 * n + 10) begin
      M_AXI_TREADY = (pattern == 0) ? 1'b1 : (cyc % 3 == 1);
      step();
      cyc++;
    end
    M_AXI_TREADY = 1'b0;
    checks++;
    if (busy !== 1'b0 || finLoad !== 1'b1) begin
      errors++;
      $display("FAIL load_done: got busy=%0b fin=%0b expected busy=0 fin=1", busy, finLoad);
    end
    checks++;
    if (beats_seen - seen0 != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_count: got %0d beats expected %0d", beats_seen - seen0, n);
      exp_q.delete();
    end
    if (pattern == 0) begin
      checks++;
      if (cyc != n + 1) begin
        errors++;
        $display("FAIL load_cycles: got %0d expected %0d", cyc, n + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    checks++;
    if (dbg_state !== 4'd0 || busy !== 1'b0 || dbg_slot !== '0 || dbg_amt_store_bytes !== '0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d busy=%0b slot=%0d len=%0d expected 0 0 0 0",
               dbg_state, busy, dbg_slot, dbg_amt_store_bytes);
    end
    checks++;
    if (S_AXI_TREADY !== 1'b0 || M_AXI_TVALID !== 1'b0 || M_AXI_TLAST !== 1'b0 || M_AXI_TDATA !== '0) begin
      errors++;
      $display("FAIL reset_axis: got tready=%0b tvalid=%0b tlast=%0b tdata=%0h expected all 0",
               S_AXI_TREADY, M_AXI_TVALID, M_AXI_TLAST, M_AXI_TDATA);
    end
    checks++;
    if ({finStore, finLoad, overflow, emptyErr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {finStore, finLoad, overflow, emptyErr});
    end
  endtask

  task automatic test_basic();
    store_words(2, 5, 32'h11, 4'hF);
    load_words(2, 5, 32'h11, 4'hF, 0);
  endtask

  task automatic test_slots();
    store_words(0, 3, 32'hA0, 4'hF);
    store_words(1, 7, 32'hB0, 4'hF);
    load_words(0, 3, 32'hA0, 4'hF, 0);
    pulse(P_LR, 1);
    checks++;
    if (dbg_slot !== 2'd1 || dbg_amt_store_bytes !== LW'(7)) begin
      errors++;
      $display("FAIL slot1_len: got slot=%0d len=%0d expected slot=1 len=7", dbg_slot, dbg_amt_store_bytes);
    end
    pulse(P_LR, 2);
    checks++;
    if (dbg_amt_store_bytes !== LW'(5)) begin
      errors++;
      $display("FAIL slot2_len: got %0d expected 5", dbg_amt_store_bytes);
    end
  endtask

  task automatic test_empty();
    pulse(P_LI, 3);
    checks++;
    if (emptyErr !== 1'b1 || dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL empty_err: got err=%0b state=%0d expected err=1 state=0", emptyErr, dbg_state);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (M_AXI_TVALID !== 1'b0 || dbg_state !== 4'd0) begin
        errors++;
        $display("FAIL empty_quiet: got tvalid=%0b state=%0d expected 0 0", M_AXI_TVALID, dbg_state);
      end
      step();
    end
    pulse(P_LR, 3);
    checks++;
    if (emptyErr !== 1'b0) begin
      errors++;
      $display("FAIL empty_clear: got %0b expected 0", emptyErr);
    end
  endtask

  task automatic test_priority();
    slotSel    = 2'd2;
    storeReset = 1'b1;
    storeInit  = 1'b1;
    step();
    storeReset = 1'b0;
    storeInit  = 1'b0;
    checks++;
    if (dbg_state !== 4'd0 || finStore !== 1'b0 || dbg_amt_store_bytes !== '0 || dbg_slot !== 2'd2) begin
      errors++;
      $display("FAIL prio_sr: got state=%0d fin=%0b len=%0d slot=%0d expected 0 0 0 2",
               dbg_state, finStore, dbg_amt_store_bytes, dbg_slot);
    end
    pulse(P_SI, 2);
    pulse(P_LI, 3);
    checks++;
    if (dbg_state !== 4'd1 || dbg_slot !== 2'd2) begin
      errors++;
      $display("FAIL busy_drop: got state=%0d slot=%0d expected state=1 slot=2", dbg_state, dbg_slot);
    end
    S_AXI_TVALID = 1'b1;
    S_AXI_TDATA  = 32'h77;
    S_AXI_TKEEP  = 4'hF;
    S_AXI_TLAST  = 1'b1;
    step();
    S_AXI_TVALID = 1'b0;
    S_AXI_TLAST  = 1'b0;
    checks++;
    if (dbg_state !== 4'd0 || finStore !== 1'b1 || dbg_amt_store_bytes !== LW'(1)) begin
      errors++;
      $display("FAIL single_beat: got state=%0d fin=%0b len=%0d expected 0 1 1",
               dbg_state, finStore, dbg_amt_store_bytes);
    end
  endtask

  task automatic test_keep();
    store_words(1, 2, 32'h55, 4'h3);
    load_words(1, 2, 32'h55, 4'h3, 0);
  endtask

  task automatic test_stall_and_abort();
    beat_t b;
    store_words(3, 4, 32'hC1, 4'hF);
    load_words(3, 4, 32'hC1, 4'hF, 1);
    for (int i = 0; i < 2; i++) begin
      b.data = 32'hC1 + DW'(i);
      b.keep = 4'hF;
      b.last = 1'b0;
      exp_q.push_back(b);
    end
    pulse(P_LI, 3);
    M_AXI_TREADY = 1'b1;
    step();
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (M_AXI_TVALID !== 1'b0 || M_AXI_TLAST !== 1'b0 || dbg_state !== 4'd0 || M_AXI_TDATA !== '0) begin
      errors++;
      $display("FAIL abort_load: got tvalid=%0b tlast=%0b state=%0d tdata=%0h expected 0 0 0 0",
               M_AXI_TVALID, M_AXI_TLAST, dbg_state, M_AXI_TDATA);
    end
    reset = 1'b1;
    step();
    M_AXI_TREADY = 1'b0;
    checks++;
    if (M_AXI_TVALID !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_beats: got tvalid=%0b pending=%0d expected 0 0", M_AXI_TVALID, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_overflow();
    int accepted;
    accepted = 0;
    pulse(P_SR, 0);
    pulse(P_SI, 0);
    for (int i = 0; i < DEPTH + 4; i++) begin
      S_AXI_TVALID = 1'b1;
      S_AXI_TDATA  = 32'h1000_0000 + DW'(i);
      S_AXI_TKEEP  = 4'hF;
      S_AXI_TLAST  = 1'b0;
      if (i == DEPTH - 1) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL overflow_early: got %0b expected 0", overflow);
        end
      end
      if (S_AXI_TREADY === 1'b1) accepted++;
      step();
    end
    S_AXI_TVALID = 1'b0;
    checks++;
    if (accepted != DEPTH || S_AXI_TREADY !== 1'b0) begin
      errors++;
      $display("FAIL overflow_accept: got %0d beats tready=%0b expected %0d beats tready=0",
               accepted, S_AXI_TREADY, DEPTH);
    end
    checks++;
    if (overflow !== 1'b1 || finStore !== 1'b1 || dbg_amt_store_bytes !== LW'(DEPTH) || dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL overflow_flags: got ovf=%0b fin=%0b len=%0d state=%0d expected 1 1 %0d 0",
               overflow, finStore, dbg_amt_store_bytes, dbg_state, DEPTH);
    end
    load_words(0, DEPTH, 32'h1000_0000, 4'hF, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slots();
    test_empty();
    test_priority();
    test_keep();
    test_stall_and_abort();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/magic_slot_streamer.md
MAGIC_SLOT_STREAMER -- requirements
Module: magic_slot_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter STORAGE_IDX_WIDTH, default 10, log2 words per slot (DEPTH = 2^STORAGE_IDX_WIDTH).
REQ-003 SHALL have parameter NUM_SLOTS, default 4, independent capture slots; SLOT_W = max(1, clog2(NUM_SLOTS)).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk in 1 (all logic on rising edge); reset in 1 (active-low, synchronous).
REQ-005 SHALL have AXIS slave ports S_AXI_TDATA in DATA_WIDTH, S_AXI_TKEEP in DATA_WIDTH/8, S_AXI_TVALID in 1, S_AXI_TREADY out 1, S_AXI_TLAST in 1.
REQ-006 SHALL have AXIS master ports M_AXI_TDATA out DATA_WIDTH, M_AXI_TKEEP out DATA_WIDTH/8, M_AXI_TVALID out 1, M_AXI_TREADY in 1, M_AXI_TLAST out 1.
REQ-007 SHALL have control inputs storeReset, loadReset, storeInit, loadInit (1 each, single-cycle pulses) and slotSel in SLOT_W, which selects the target slot.
REQ-008 SHALL have outputs finStore 1 (sticky store done), finLoad 1 (sticky load done), overflow 1 (sticky), emptyErr 1 (sticky), busy 1, dbg_state out 4, dbg_slot out SLOT_W, dbg_amt_store_bytes and dbg_amt_load_bytes out STORAGE_IDX_WIDTH+1 (active slot counts).

Function
REQ-009 SHALL implement states IDLE=0, STORE=1, LOAD_PRIME=2, LOAD=3; busy = (state != IDLE).
REQ-010 SHALL latch slotSel into the active-slot register on any accepted control pulse in IDLE; slotSel is ignored outside IDLE.
REQ-011 In IDLE, pulses SHALL be accepted in priority storeReset > loadReset > storeInit > loadInit, one per cycle; pulses arriving outside IDLE are dropped.
REQ-012 storeReset SHALL zero the selected slot's store length and clear finStore and overflow; loadReset SHALL zero the selected slot's load pointer and clear finLoad and emptyErr.
REQ-013 storeInit SHALL enter STORE and restart the selected slot's write pointer at 0.
REQ-014 S_AXI_TREADY SHALL be 1 exactly when state == STORE, independent of S_AXI_TVALID.
REQ-015 Each STORE beat (TVALID & TREADY) SHALL write TDATA (and TKEEP, per REQ-027) at the write pointer, then increment the pointer and the slot length.
REQ-016 A beat with TLAST SHALL set finStore and return to IDLE on the next edge.
REQ-017 A beat written to word DEPTH-1 without TLAST SHALL set overflow, set finStore and return to IDLE; slot length = DEPTH; further input stalls (TREADY = 0).
REQ-018 loadInit on a slot with length 0 SHALL set emptyErr, remain IDLE and emit no beat.
REQ-019 loadInit on a non-empty slot SHALL enter LOAD_PRIME for exactly 1 cycle (synchronous memory read of the word at the load pointer), then LOAD.
REQ-020 In LOAD, M_AXI_TVALID SHALL be 1, M_AXI_TDATA/TKEEP held stable from the output register until handshake; TLAST = (load pointer == length-1).
REQ-021 A LOAD handshake SHALL advance the pointer and prefetch the next word so back-to-back beats sustain 1 beat/cycle (no bubble after first beat).
REQ-022 The TLAST handshake SHALL set finLoad, zero the load pointer and return to IDLE.
REQ-023 Lengths SHALL be STORAGE_IDX_WIDTH+1 bits unsigned, never wrap; slots SHALL be fully independent (a store to slot A does not alter slot B).
REQ-024 Outside LOAD, M_AXI_TVALID and M_AXI_TLAST SHALL be 0.

Reset
REQ-025 reset=0 at a clk edge SHALL force IDLE, active slot 0, all lengths and pointers 0, finStore/finLoad/overflow/emptyErr 0, S_AXI_TREADY/M_AXI_TVALID/M_AXI_TLAST 0, M_AXI_TDATA 0; memory contents are not cleared.
REQ-026 Reset mid-STORE or mid-LOAD SHALL abort immediately with no further beat accepted or emitted.

Configuration
REQ-027 Macro MAGIC_STREAMER_KEEP_STORE_EN: defined -> TKEEP stored per word and replayed on M_AXI_TKEEP; undefined -> no TKEEP storage, M_AXI_TKEEP constant all-ones, S_AXI_TKEEP ignored.

Verification
REQ-028 Store 5 words 0x11..0x15 (TLAST on 5th) to slot 2, load slot 2 with TREADY=1 -> finStore=1, 5 beats 0x11..0x15 back-to-back, TLAST only on 0x15, finLoad=1.
REQ-029 Store 3 words to slot 0 and 7 to slot 1, load slot 0 -> exactly 3 beats; dbg_amt_store_bytes for slot 1 reads 7.
REQ-030 Store DEPTH+4 words with no TLAST -> overflow=1 after DEPTH beats, TREADY=0 thereafter, replay emits DEPTH beats with TLAST on last.
REQ-031 loadInit on freshly reset slot 3 -> emptyErr=1, M_AXI_TVALID stays 0, state stays 0.
REQ-032 Load 4 words with TREADY toggling 1,0,0,1,... -> data held stable while stalled, order preserved, TLAST on word 4; assert reset mid-load -> next cycle TVALID=0, state 0.
REQ-033 With MAGIC_STREAMER_KEEP_STORE_EN defined, store TKEEP 0xF,0x3 -> replay 0xF,0x3; undefined -> replay 0xF,0xF.
